pmu_sweep_collector: RTL and testbench
======================================

Name: pmu_sweep_collector

Overview:
- Downstream consumer of the mesh-with-loaders PMU read ports.
- After a traffic run (start pulse), waits for every loader to go idle, then sweeps all PMU counter registers of all N nodes.
- Streams the counter values out as a single AXI-Stream packet to the cosim host interface.
- Sits between the mesh's pmu_addr/pmu_data/idle ports and the host link.

Parameters:
- N, 16, number of mesh nodes / loaders.
- PMU_REGS, 8, counters read per node; addresses 0..PMU_REGS-1 (PMU_REGS ≤ 32).
- DATA_WIDTH, 32, PMU counter and stream word width.
- SETTLE_CYCLES, 4, minimum cycles after start_i before idle is evaluated.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- start_i  in  1  same start pulse given to the loaders; arms a sweep.
- idle_i  in  1 x [N]  loader idle flags.
- pmu_addr_o  out  5 x [N]  PMU register address; the same value is driven to all nodes.
- pmu_data_i  in  DATA_WIDTH x [N]  PMU read data; valid 1 cycle after the address changes.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tdata  out  DATA_WIDTH  counter value.
- m_tlast  out  1  last word of sweep.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-sweep aborts immediately; no further beats are emitted.
- IDLE:
  - start_i=1 -> SETTLE, settle counter cleared.
  - start_i=0 -> stay in IDLE.
- SETTLE:
  - Count SETTLE_CYCLES cycles, ignoring idle_i, then go to WAIT_IDLE.
- WAIT_IDLE:
  - Requires the AND of all idle_i to be high on 2 consecutive cycles.
  - Then node=0, reg=0, go to ADDR.
  - No timeout; waits indefinitely.
- ADDR:
  - pmu_addr_o = reg for all nodes; one cycle, then CAPTURE.
- CAPTURE:
  - Register pmu_data_i[node] into m_tdata.
  - m_tlast = (node==N-1 && reg==PMU_REGS-1).
  - Assert m_tvalid, go to SEND.
- SEND:
  - Hold m_tdata, m_tlast and m_tvalid stable until m_tready=1 (standard AXI-S; valid never drops without a handshake).
  - On handshake with last=0: increment reg; when reg wraps to 0, increment node. Go to ADDR (m_tvalid=0 next cycle).
  - On handshake with last=1: pulse done_o, go to IDLE.
- Throughput and ordering:
  - Max 1 word per 3 cycles; node-major, reg-minor order.
  - Packet length exactly N*PMU_REGS words.
- start_i outside IDLE is ignored; no queueing.
- m_tready held low indefinitely stalls in SEND with data held.
- pmu_addr_o holds its last value outside ADDR/CAPTURE/SEND (0 after reset).
- Counters: node is $clog2(N) bits, reg is 5 bits, no overflow beyond the declared ranges.
- idle_i glitching low during the 2-cycle qualification restarts the qualification.

Optional Feature:
- Macro PMU_SWEEP_HEADER_EN.
- Defined:
  - After idle qualification, one header word is sent before node 0, reg 0.
  - Header layout: [31:16] = sweep count (16-bit, increments per completed sweep, wraps 0xFFFF->0), [15:8] = N, [7:0] = PMU_REGS.
  - Header has m_tlast=0; packet length becomes N*PMU_REGS+1.
  - Sweep count resets to 0.
- Undefined: no header; the sweep counter is not instantiated.

Test Plan:
- Basic sweep: N=16, PMU_REGS=8, pmu_data_i[n] = (n<<8)|addr, m_tready=1, idle_i all high, start_i pulse -> 128 beats 0x0000..0x0F07 in order, tlast only on 0x0F07, done_o pulse once, busy_o low afterwards.
- Wait for idle: idle_i[5]=0 until 100 cycles after start -> first beat no earlier than cycle 100+2+1; no beats before then.
- Backpressure: m_tready toggling 1-of-3 cycles, random stalls -> identical 128-word sequence, m_tdata stable while m_tvalid=1 and m_tready=0.
- Re-start ignored: second start_i at beat 40 -> still exactly one packet of 128 beats, one done_o.
- Reset mid-sweep: areset at beat 50 -> all outputs 0 next cycle; a new start yields a complete fresh 128-beat packet starting at 0x0000.
- Header (PMU_SWEEP_HEADER_EN): two consecutive sweeps -> first beats 0x0000_1008 then 0x0001_1008, each packet 129 beats.

Source files
------------

// File: rtl/pmu_sweep_collector.sv
// ============================================================================
// Module   : pmu_sweep_collector
// Purpose  : After a traffic run, waits for all loaders to go idle, sweeps every
//            PMU counter of every node and streams them as one AXI-Stream packet.
//            Optional header word enabled by macro PMU_SWEEP_HEADER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmu_sweep_collector #(
    parameter int N             = 16,
    parameter int PMU_REGS      = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           start_i,
    input  logic [N-1:0]                   idle_i,
    output logic [N-1:0][4:0]              pmu_addr_o,
    input  logic [N-1:0][DATA_WIDTH-1:0]   pmu_data_i,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic                           m_tlast,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int NODE_W   = (N > 1) ? $clog2(N) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [NODE_W-1:0]   c_LAST_NODE   = NODE_W'(N - 1);
    localparam logic [4:0]          c_LAST_REG    = 5'(PMU_REGS - 1);
    localparam logic [SETTLE_W-1:0] c_SETTLE_LAST = SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_WAIT_IDLE = 3'd2,
        S_ADDR      = 3'd3,
        S_CAPTURE   = 3'd4,
        S_SEND      = 3'd5,
        S_HDR       = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [SETTLE_W-1:0]   r_settle;
    logic                  r_idle_seen;
    logic [NODE_W-1:0]     r_node;
    logic [4:0]            r_reg;
    logic [4:0]            r_addr;
    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tlast;
    logic                  r_done;

    logic                  w_all_idle;
    logic                  w_qualified;
    logic                  w_reg_wrap;
    logic [4:0]            w_reg_next;
    logic [NODE_W-1:0]     w_node_next;
    logic                  w_last;

`ifdef PMU_SWEEP_HEADER_EN
    logic [15:0]           r_sweep_cnt;
    logic                  r_hdr;
`endif

    assign w_all_idle  = &idle_i;
    // Idle must be seen on two consecutive WAIT_IDLE cycles; any low sample restarts it.
    assign w_qualified = w_all_idle && r_idle_seen;
    assign w_reg_wrap  = (r_reg == c_LAST_REG);
    assign w_reg_next  = w_reg_wrap ? 5'd0 : r_reg + 5'd1;
    assign w_node_next = w_reg_wrap ? r_node + NODE_W'(1) : r_node;
    assign w_last      = (r_node == c_LAST_NODE) && w_reg_wrap;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (start_i) w_state_next = S_SETTLE;
            S_SETTLE:    if (r_settle == c_SETTLE_LAST) w_state_next = S_WAIT_IDLE;
            S_WAIT_IDLE: begin
                if (w_qualified) begin
`ifdef PMU_SWEEP_HEADER_EN
                    w_state_next = S_HDR;
`else
                    w_state_next = S_ADDR;
`endif
                end
            end
            S_ADDR:      w_state_next = S_CAPTURE;
            S_CAPTURE:   w_state_next = S_SEND;
            S_HDR:       w_state_next = S_SEND;
            S_SEND:      if (m_tready) w_state_next = r_tlast ? S_IDLE : S_ADDR;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_idle_seen <= 1'b0;
            r_node      <= '0;
            r_reg       <= '0;
            r_addr      <= '0;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_done      <= 1'b0;
`ifdef PMU_SWEEP_HEADER_EN
            r_sweep_cnt <= '0;
            r_hdr       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_done      <= 1'b0;
            r_idle_seen <= (r_state == S_WAIT_IDLE) && w_all_idle;
            case (r_state)
                S_IDLE: begin
                    if (start_i) r_settle <= '0;
                end
                S_SETTLE: begin
                    r_settle <= r_settle + SETTLE_W'(1);
                end
                S_WAIT_IDLE: begin
                    if (w_qualified) begin
                        r_node <= '0;
                        r_reg  <= '0;
                        r_addr <= '0;
                    end
                end
`ifdef PMU_SWEEP_HEADER_EN
                S_HDR: begin
                    r_tdata  <= DATA_WIDTH'({r_sweep_cnt, 8'(N), 8'(PMU_REGS)});
                    r_tlast  <= 1'b0;
                    r_tvalid <= 1'b1;
                    r_hdr    <= 1'b1;
                end
`endif
                S_CAPTURE: begin
                    r_tdata  <= pmu_data_i[r_node];
                    r_tlast  <= w_last;
                    r_tvalid <= 1'b1;
                end
                S_SEND: begin
                    if (m_tready) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
`ifdef PMU_SWEEP_HEADER_EN
                        if (r_hdr) begin
                            r_hdr <= 1'b0;
                        end else if (r_tlast) begin
                            r_done      <= 1'b1;
                            r_sweep_cnt <= r_sweep_cnt + 16'd1;
                        end else begin
                            r_reg  <= w_reg_next;
                            r_node <= w_node_next;
                            r_addr <= w_reg_next;
                        end
`else
                        if (r_tlast) begin
                            r_done <= 1'b1;
                        end else begin
                            r_reg  <= w_reg_next;
                            r_node <= w_node_next;
                            r_addr <= w_reg_next;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign pmu_addr_o = {N{r_addr}};
    assign m_tvalid   = r_tvalid;
    assign m_tdata    = r_tdata;
    assign m_tlast    = r_tlast;
    assign done_o     = r_done;
    assign busy_o     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pmu_sweep_collector.sv
// ============================================================================
// Module   : tb_pmu_sweep_collector
// Purpose  : Scoreboard bench for pmu_sweep_collector (honours PMU_SWEEP_HEADER_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmu_sweep_collector;

    localparam int N        = 16;
    localparam int PMU_REGS = 8;
    localparam int DW       = 32;
`ifdef PMU_SWEEP_HEADER_EN
    localparam int PKT = N * PMU_REGS + 1;
`else
    localparam int PKT = N * PMU_REGS;
`endif

    logic                   aclk = 1'b0;
    logic                   areset = 1'b1;
    logic                   start_i = 1'b0;
    logic [N-1:0]           idle_i = '1;
    logic [N-1:0][4:0]      pmu_addr_o;
    logic [N-1:0][DW-1:0]   pmu_data_i = '0;
    logic                   m_tvalid;
    logic                   m_tready = 1'b0;
    logic [DW-1:0]          m_tdata;
    logic                   m_tlast;
    logic                   busy_o;
    logic                   done_o;

    pmu_sweep_collector #(
        .N(N), .PMU_REGS(PMU_REGS), .DATA_WIDTH(DW), .SETTLE_CYCLES(4)
    ) dut (
        .aclk(aclk), .areset(areset), .start_i(start_i), .idle_i(idle_i),
        .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 aclk = ~aclk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          rdy_mode = 0;
    int          beats   = 0;
    int          dones   = 0;
    int          first_cyc = 0;
    int          start_cyc = 0;
    logic [15:0] hdr_cnt = '0;
    logic [DW:0] sb [$];

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // PMU model: read data follows the address with one cycle of latency.
    always @(posedge aclk)
        for (int n = 0; n < N; n++)
            pmu_data_i[n] <= DW'((n << 8) | int'(pmu_addr_o[n]));

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 3 == 0);
            default: m_tready = ($urandom_range(0, 3) == 0);
        endcase
    end

    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_tvalid), 64'd1);
                check("hold_data", 64'(m_tdata), 64'(prev_data));
                check("hold_last", 64'(m_tlast), 64'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 64'(sb.size()), 64'd1);
                end else begin
                    check("beat", 64'({m_tlast, m_tdata}), 64'(sb.pop_front()));
                end
                if (beats == 0) first_cyc = cyc;
                beats++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (done_o) dones++;
        end
    end

    task automatic push_sweep();
`ifdef PMU_SWEEP_HEADER_EN
        sb.push_back({1'b0, DW'({hdr_cnt, 8'(N), 8'(PMU_REGS)})});
`endif
        for (int n = 0; n < N; n++)
            for (int r = 0; r < PMU_REGS; r++)
                sb.push_back({(n == N - 1 && r == PMU_REGS - 1), DW'((n << 8) | r)});
    endtask

    task automatic pulse_start();
        @(posedge aclk); #1 start_i = 1'b1;
        @(posedge aclk); #1 start_i = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8000 && sb.size() != 0; i++) @(posedge aclk);
        check(tag, 64'(sb.size()), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic wait_beats(input int target);
        for (int i = 0; i < 8000 && beats < target; i++) @(posedge aclk);
        check("reach_beat", 64'(beats >= target), 64'd1);
    endtask

    task automatic run_sweep(input int mode, input string tag);
        int d0;
        rdy_mode = mode;
        d0 = dones;
        beats = 0;
        push_sweep();
        pulse_start();
        drain(tag);
        check("done_once", 64'(dones - d0), 64'd1);
        check("beat_count", 64'(beats), 64'(PKT));
        check("busy_after", 64'(busy_o), 64'd0);
        hdr_cnt = hdr_cnt + 16'd1;
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        #1;
        check("rst_valid", 64'(m_tvalid), 64'd0);
        check("rst_data", 64'(m_tdata), 64'd0);
        check("rst_last", 64'(m_tlast), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_addr", 64'(pmu_addr_o), 64'd0);

        run_sweep(0, "basic");
        check("addr_hold", 64'(pmu_addr_o[0]), 64'(PMU_REGS - 1));

        // Loader 5 stays busy for 100 cycles after start.
        rdy_mode = 0;
        idle_i[5] = 1'b0;
        beats = 0;
        d0 = dones;
        push_sweep();
        pulse_start();
        check("busy_wait", 64'(busy_o), 64'd1);
        repeat (100) @(posedge aclk);
        #1 idle_i[5] = 1'b1;
        drain("idle_wait");
        check("first_beat_late", 64'((first_cyc + 1 - start_cyc) >= 103), 64'd1);
        check("idle_done", 64'(dones - d0), 64'd1);
        hdr_cnt = hdr_cnt + 16'd1;

        run_sweep(1, "bp_1of3");
        run_sweep(2, "bp_random");

        // Second start in the middle of a packet must be ignored.
        rdy_mode = 2;
        beats = 0;
        d0 = dones;
        push_sweep();
        pulse_start();
        wait_beats(40);
        pulse_start();
        drain("restart");
        repeat (40) @(posedge aclk);
        #1;
        check("restart_beats", 64'(beats), 64'(PKT));
        check("restart_done", 64'(dones - d0), 64'd1);
        check("restart_busy", 64'(busy_o), 64'd0);
        hdr_cnt = hdr_cnt + 16'd1;

        // Reset in the middle of a packet aborts it.
        rdy_mode = 0;
        beats = 0;
        push_sweep();
        pulse_start();
        wait_beats(50);
        #1 areset = 1'b1;
        @(posedge aclk); #1;
        check("mid_rst_valid", 64'(m_tvalid), 64'd0);
        check("mid_rst_data", 64'(m_tdata), 64'd0);
        check("mid_rst_last", 64'(m_tlast), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_addr", 64'(pmu_addr_o), 64'd0);
        areset = 1'b0;
        sb.delete();
        hdr_cnt = '0;
        repeat (20) @(posedge aclk);
        #1 check("mid_rst_quiet", 64'(m_tvalid), 64'd0);
        run_sweep(0, "after_rst");
        run_sweep(2, "after_rst2");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
